// File: rtl/ed25519_pkg.sv
// Shared definitions for the ed25519 operand-bank arbiter: FSM encoding,
// protected constant-region bounds and the maximum read burst length.
package ed25519_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_RBURST = 2'd2
  } state_t;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned DEF_PROT_LO_END  = 15;
  localparam int unsigned DEF_PROT_HI_BASE = 112;
  localparam int unsigned DEF_PROT_HI_END  = 135;

  // A burst length field of zero encodes BURST_MAX beats.
  localparam int unsigned BURST_MAX = 16;
  localparam int unsigned BEAT_W    = $clog2(BURST_MAX);

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/ed25519_addr_guard.sv
// Flags word addresses inside the protected low/high constant regions
// (bounds inclusive); purely combinational.
module ed25519_addr_guard
  import ed25519_pkg::*;
#(
  parameter int unsigned PROT_LO_END  = DEF_PROT_LO_END,
  parameter int unsigned PROT_HI_BASE = DEF_PROT_HI_BASE,
  parameter int unsigned PROT_HI_END  = DEF_PROT_HI_END
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              prot
);

  localparam logic [ADDR_W-1:0] LO_END  = ADDR_W'(PROT_LO_END);
  localparam logic [ADDR_W-1:0] HI_BASE = ADDR_W'(PROT_HI_BASE);
  localparam logic [ADDR_W-1:0] HI_END  = ADDR_W'(PROT_HI_END);

  assign prot = (addr <= LO_END) || ((addr >= HI_BASE) && (addr <= HI_END));

endmodule

// File: rtl/ed25519_bank_arbiter.sv
// Arbitrates one single-word writer and one burst reader onto a single bank port.
// Write ack 1 cycle after grant; read data 1 cycle behind each address; losers wait in IDLE.
module ed25519_bank_arbiter
  import ed25519_pkg::*;
#(
  parameter int unsigned PROT_LO_END  = DEF_PROT_LO_END,
  parameter int unsigned PROT_HI_BASE = DEF_PROT_HI_BASE,
  parameter int unsigned PROT_HI_END  = DEF_PROT_HI_END
) (
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iW_req,
  input  logic [ADDR_W-1:0] iW_addr,
  input  logic [DATA_W-1:0] iW_data,
  output logic              oW_ack,
  output logic              oW_err,
  input  logic              iR_req,
  input  logic [ADDR_W-1:0] iR_addr,
  input  logic [BEAT_W-1:0] iR_len,
  output logic              oR_ack,
  output logic              oR_valid,
  output logic [DATA_W-1:0] oR_data,
  output logic              oR_last,
  output logic [ADDR_W-1:0] oBank_addr,
  output logic              oBank_wr,
  output logic [DATA_W-1:0] oBank_wdata,
  input  logic [DATA_W-1:0] iBank_rdata
);

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [ADDR_W-1:0]   r_addr;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   last_idx;
  logic                rd_vld;
  logic                rd_last;
  logic                w_prot;
  logic                grant_w;
  logic                grant_r;
  logic                burst_end;

  ed25519_addr_guard #(
    .PROT_LO_END  (PROT_LO_END),
    .PROT_HI_BASE (PROT_HI_BASE),
    .PROT_HI_END  (PROT_HI_END)
  ) u_guard (
    .addr (w_addr),
    .prot (w_prot)
  );

  // On a tie the requester that was not served last wins, so neither side starves.
  assign grant_w   = (state == ST_IDLE) && iW_req && (!iR_req || (last_grant == GRANT_RD));
  assign grant_r   = (state == ST_IDLE) && iR_req && !grant_w;
  assign burst_end = (state == ST_RBURST) && (beat == last_idx);

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_RD;
      w_addr     <= '0;
      w_data     <= '0;
      r_addr     <= '0;
      beat       <= '0;
      last_idx   <= '0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_vld  <= (state == ST_RBURST);
      rd_last <= burst_end;
      case (state)
        ST_IDLE: begin
          if (grant_w) begin
            w_addr     <= iW_addr;
            w_data     <= iW_data;
            last_grant <= GRANT_WR;
          end else if (grant_r) begin
            r_addr     <= iR_addr;
            beat       <= '0;
            // Length 0 wraps to the all-ones index, i.e. a full BURST_MAX burst.
            last_idx   <= iR_len - BEAT_W'(1);
            last_grant <= GRANT_RD;
          end
        end
        ST_RBURST: begin
          r_addr <= r_addr + ADDR_W'(1);
          beat   <= beat + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    oW_ack      = 1'b0;
    oW_err      = 1'b0;
    oR_ack      = 1'b0;
    oBank_addr  = '0;
    oBank_wr    = 1'b0;
    oBank_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (grant_w) begin
          state_nxt = ST_WRITE;
        end else if (grant_r) begin
          state_nxt = ST_RBURST;
        end
      end
      ST_WRITE: begin
        oW_ack    = 1'b1;
        oW_err    = w_prot;
        state_nxt = ST_IDLE;
        if (!w_prot) begin
          oBank_wr    = 1'b1;
          oBank_addr  = w_addr;
          oBank_wdata = w_data;
        end
      end
      ST_RBURST: begin
        oBank_addr = r_addr;
        oR_ack     = (beat == '0);
        if (burst_end) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign oR_valid = rd_vld;
  assign oR_last  = rd_last;
  assign oR_data  = rd_vld ? iBank_rdata : '0;

endmodule

// File: doc/ed25519_bank_arbiter.md
ED25519_BANK_ARBITER -- requirements
Module: ed25519_bank_arbiter

Interface
REQ-001 SHALL have parameter PROT_LO_END, default 15, meaning last address of protected low constant region (0..PROT_LO_END).
REQ-002 SHALL have parameter PROT_HI_BASE, default 112, and PROT_HI_END, default 135, meaning protected high constant region.
REQ-003 SHALL have ports: iClk input 1 clock; iRstn input 1 asynchronous active-low reset.
REQ-004 Writer: iW_req in 1 write request; iW_addr in 9 word address; iW_data in 32 data; oW_ack out 1 one-cycle completion; oW_err out 1 protected-address reject, valid with oW_ack.
REQ-005 Reader: iR_req in 1 burst request; iR_addr in 9 start address; iR_len in 4 burst length (0 encodes 16); oR_ack out 1 one-cycle accept; oR_valid out 1 data valid; oR_data out 32 read word; oR_last out 1 final word of burst.
REQ-006 Bank side: oBank_addr out 9; oBank_wr out 1; oBank_wdata out 32; iBank_rdata in 32 (bank read data, one cycle after address).

Function
REQ-007 SHALL implement FSM states IDLE, WRITE, RBURST.
REQ-008 In IDLE, sampled requests select next state at the clock edge: only iW_req -> WRITE; only iR_req -> RBURST; both -> the requester not granted last (last_grant reg).
REQ-009 On grant SHALL latch address, data or address/length; requesters hold request and operands stable until their ack.
REQ-010 WRITE lasts exactly one cycle: oW_ack=1; if address unprotected, oBank_wr=1, oBank_addr/oBank_wdata = latched values, oW_err=0; if protected, oBank_wr=0, oW_err=1. Next state IDLE.
REQ-011 Protected: addr<=PROT_LO_END, or PROT_HI_BASE<=addr<=PROT_HI_END; boundaries inclusive.
REQ-012 RBURST lasts N cycles (N=iR_len, 16 if 0); cycle k (0..N-1) drives oBank_addr=start+k mod 512, oBank_wr=0; oR_ack=1 in cycle 0 only.
REQ-013 oR_valid=1 exactly one cycle after each RBURST cycle, oR_data=iBank_rdata combinationally; oR_last=1 with the Nth valid word.
REQ-014 Address wrap: 511 increments to 0 with no error.
REQ-015 After WRITE or last RBURST cycle, FSM SHALL return to IDLE (one-cycle bubble); last_grant updated to the served requester.
REQ-016 Requests arriving outside IDLE SHALL wait; no request dropped; writer waits at most one burst (<=17 cycles) when reader requests continuously.
REQ-017 When not in WRITE/RBURST, oBank_wr=0, oBank_addr=0, oBank_wdata=0.
REQ-018 Latency: write request sampled at cycle t -> oW_ack at t+1; read request sampled at t -> oR_ack t+1, first oR_valid t+2, oR_last t+1+N.

Reset
REQ-019 Async assertion of iRstn=0 SHALL force IDLE, last_grant=reader, all outputs 0 including oR_valid pipeline, immediately, even mid-burst; aborted burst produces no further oR_valid.
REQ-020 Operation resumes on first clock edge after deassertion.

Structure
REQ-021 FSM state encoding, protected-region bounds and burst max (16) SHALL reside in shared package ed25519_pkg.
REQ-022 Protection check SHALL be a sub-module ed25519_addr_guard (9-bit address in, 1-bit protected out); remainder single module.

Verification
REQ-023 Write addr 200 data 0xDEADBEEF -> oW_ack next cycle, oBank_wr=1, addr 200, oW_err=0.
REQ-024 Writes to 15, 16, 111, 112, 135, 136 -> oW_err=1,0,0,1,1,0; oBank_wr=0 only for errored writes.
REQ-025 Read addr 510 len 4 -> oBank_addr 510,511,0,1; four oR_valid, oR_last on fourth, data matches bank model.
REQ-026 Read len 0 -> 16 valid words; simultaneous writer and reader requests from reset -> writer first, then reader, then alternate.
REQ-027 Continuous reader requests plus pending write -> write acked within 17 cycles.
REQ-028 iRstn low during cycle 3 of 8-word burst -> all outputs 0 immediately, no further oR_valid, IDLE after release.
